// File: rtl/load_store_unit.sv
// Load/store unit bridging execute-stage requests to data_memory; misaligned
// halfword/word accesses are carried out as ascending byte beats.
module load_store_unit #(
    parameter int DMEM_DATA_WIDTH = 32,
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DMEM_DATA_WIDTH-1:0] rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_split,
    output logic                       mem_wr_en,
    output logic [1:0]                 mem_rw_mode,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DMEM_DATA_WIDTH-1:0] mem_w_data,
    input  logic [DMEM_DATA_WIDTH-1:0] mem_r_data
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BEAT = 2'd1, S_RESP = 2'd2} state_t;

    state_t                       r_state;
    logic   [1:0]                 r_beat;
    logic   [DMEM_DATA_WIDTH-1:0] r_rdata;
    logic                         r_err;
    logic                         r_rsp_split;
    logic                         r_mem_wr_en;
    logic   [1:0]                 r_mem_rw_mode;
    logic   [DMEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic   [DMEM_DATA_WIDTH-1:0] r_mem_w_data;

    logic                         r_we;
    logic   [1:0]                 r_size;
    logic                         r_uns;
    logic   [DMEM_DATA_WIDTH-1:0] r_wdata;
    logic                         r_split;
    logic   [DMEM_DATA_WIDTH-1:0] r_asm;

    logic                         w_hs;
    logic                         w_req_split;
    logic                         w_last;
    logic   [DMEM_DATA_WIDTH-1:0] w_asm_next;

    function automatic logic f_split(input logic [1:0] size, input logic [1:0] a);
        return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
    endfunction

    function automatic logic [1:0] f_last_beat(input logic [1:0] size, input logic split);
        if (!split)
            return 2'd0;
        return (size == SZ_HALF) ? 2'd1 : 2'd3;
    endfunction

    function automatic logic [DMEM_DATA_WIDTH-1:0] f_beat_wdata(
        input logic [DMEM_DATA_WIDTH-1:0] d, input logic [1:0] k);
        return {{(DMEM_DATA_WIDTH-8){1'b0}}, d[8*k +: 8]};
    endfunction

    function automatic logic [DMEM_DATA_WIDTH-1:0] f_extend(
        input logic [DMEM_DATA_WIDTH-1:0] d, input logic [1:0] size, input logic uns);
        case (size)
            SZ_BYTE: return {{(DMEM_DATA_WIDTH-8){d[7] & ~uns}}, d[7:0]};
            SZ_HALF: return {{(DMEM_DATA_WIDTH-16){d[15] & ~uns}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign w_hs        = req_valid && (r_state == S_IDLE);
    assign w_req_split = f_split(req_size, req_addr[1:0]);
    assign w_last      = (r_beat == f_last_beat(r_size, r_split));

    // Byte assembly including the beat currently on the bus.
    always_comb begin
        w_asm_next = r_asm;
        if (r_split)
            w_asm_next[8*r_beat +: 8] = mem_r_data[7:0];
        else
            w_asm_next = mem_r_data;
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
            r_split <= w_req_split;
            r_asm   <= '0;
        end else if (r_state == S_BEAT) begin
            r_asm <= w_asm_next;
        end
    end

    // Memory port is registered: each beat's values are loaded one edge ahead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_beat        <= 2'd0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_rsp_split   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_rw_mode <= SZ_BYTE;
            r_mem_addr    <= '0;
            r_mem_w_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_beat <= 2'd0;
                        if (req_size == SZ_ILL) begin
                            r_state     <= S_RESP;
                            r_err       <= 1'b1;
                            r_rdata     <= '0;
                            r_rsp_split <= 1'b0;
                        end else begin
                            r_state       <= S_BEAT;
                            r_mem_wr_en   <= req_we;
                            r_mem_rw_mode <= w_req_split ? SZ_BYTE : req_size;
                            r_mem_addr    <= req_addr;
                            r_mem_w_data  <= w_req_split ? f_beat_wdata(req_wdata, 2'd0) : req_wdata;
                        end
                    end
                end
                S_BEAT: begin
                    if (w_last) begin
                        r_state       <= S_RESP;
                        r_mem_wr_en   <= 1'b0;
                        r_mem_rw_mode <= SZ_BYTE;
                        r_mem_addr    <= '0;
                        r_mem_w_data  <= '0;
                        r_err         <= 1'b0;
                        r_rsp_split   <= r_split;
                        r_rdata       <= r_we ? '0 : f_extend(w_asm_next, r_size, r_uns);
                    end else begin
                        r_beat       <= r_beat + 2'd1;
                        r_mem_addr   <= r_mem_addr + 1'b1;
                        r_mem_w_data <= f_beat_wdata(r_wdata, r_beat + 2'd1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
                        r_rsp_split <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign rsp_split   = r_rsp_split;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_rw_mode = r_mem_rw_mode;
    assign mem_addr    = r_mem_addr;
    assign mem_w_data  = r_mem_w_data;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array memory model and a
// byte-level reference model of load/store semantics.
module tb_load_store_unit;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_split;
    logic          mem_wr_en;
    logic [1:0]    mem_rw_mode;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_w_data;
    logic [31:0]   mem_r_data;

    always #5 clk = ~clk;

    load_store_unit #(.DMEM_DATA_WIDTH(32), .DMEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_split(rsp_split),
        .mem_wr_en(mem_wr_en), .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        split;
        int          lat;
        int          wr;
        logic [1:0]  mode;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    logic [7:0]  dmem    [4096];
    logic [7:0]  ref_mem [4096];

    int          hs_cyc = 0;
    int          rise_cyc = 0;
    int          wr_cnt = 0;
    logic        prev_v = 1'b0;
    logic        beat_seen = 1'b0;
    logic [1:0]  first_mode = 2'b00;
    logic [31:0] h_rdata = '0;
    logic [1:0]  h_flags = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 7) ^ (i >> 3));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // data_memory stand-in: combinational read, write on the rising edge.
    always_comb begin
        case (mem_rw_mode)
            2'b01:   mem_r_data = {16'h0, dmem[mem_addr + 12'd1], dmem[mem_addr]};
            2'b10:   mem_r_data = {dmem[mem_addr + 12'd3], dmem[mem_addr + 12'd2],
                                   dmem[mem_addr + 12'd1], dmem[mem_addr]};
            default: mem_r_data = {24'h0, dmem[mem_addr]};
        endcase
    end

    initial begin
        for (int i = 0; i < 4096; i++) dmem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_wr_en) begin
                dmem[mem_addr] = mem_w_data[7:0];
                if (mem_rw_mode != 2'b00) dmem[mem_addr + 12'd1] = mem_w_data[15:8];
                if (mem_rw_mode == 2'b10) begin
                    dmem[mem_addr + 12'd2] = mem_w_data[23:16];
                    dmem[mem_addr + 12'd3] = mem_w_data[31:24];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Reference: an access touches bytes addr..addr+n-1 (mod 4096) little-endian.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [AW-1:0] addr);
        exp_t        e;
        int          n;
        logic [31:0] v;
        e.err   = (size == 2'b11);
        e.split = !e.err && (((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00)));
        n       = e.err ? 0 : (1 << size);
        e.lat   = e.err ? 1 : (e.split ? 1 + n : 2);
        e.wr    = (we && !e.err) ? (e.split ? n : 1) : 0;
        e.mode  = e.split ? 2'b00 : size;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[12'(addr + 12'(i))]) << (8 * i));
        if (!uns && (size == 2'b00) && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && (size == 2'b01) && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = (we || e.err) ? 32'h0 : v;
        return e;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [AW-1:0] addr, input logic [31:0] wd);
        if (size != 2'b11)
            for (int i = 0; i < (1 << size); i++) ref_mem[12'(addr + 12'(i))] = wd[8*i +: 8];
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd, input bit push);
        int t = 0;
        @(posedge clk);
        #1;
        while (!req_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        if (push) begin
            sb.push_back(model(we, size, uns, addr));
            if (we) ref_store(size, addr, wd);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = 12'($urandom); req_wdata = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || rsp_valid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: port legality, hold-under-backpressure and scoreboard pops.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 1'b0; wr_cnt = 0; beat_seen = 1'b0;
            end else begin
                check("ready_valid_excl", 32'(req_ready && rsp_valid), 32'd0);
                if (req_ready || rsp_valid) begin
                    check("mem_idle_zero", mem_w_data | 32'(mem_addr) | 32'(mem_rw_mode) | 32'(mem_wr_en), 32'd0);
                end else begin
                    check("mem_beat_legal", 32'((mem_rw_mode == 2'b11) ||
                          ((mem_rw_mode == 2'b01) && mem_addr[0]) ||
                          ((mem_rw_mode == 2'b10) && (mem_addr[1:0] != 2'b00))), 32'd0);
                    if (!beat_seen) first_mode = mem_rw_mode;
                    beat_seen = 1'b1;
                    if (mem_wr_en) wr_cnt++;
                end
                if (prev_v) begin
                    check("hold_valid", 32'(rsp_valid), 32'd1);
                    check("hold_rdata", rsp_rdata, h_rdata);
                    check("hold_flags", 32'({rsp_err, rsp_split}), 32'(h_flags));
                end
                if (rsp_valid && !prev_v) rise_cyc = cyc;
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got a response, expected none (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("rsp_split", 32'(rsp_split), 32'(e.split));
                        check("latency", 32'(rise_cyc - hs_cyc + 1), 32'(e.lat));
                        check("wr_pulses", 32'(wr_cnt), 32'(e.wr));
                        if (!e.err) check("beat_mode", 32'(first_mode), 32'(e.mode));
                        else        check("err_no_beat", 32'(beat_seen), 32'd0);
                    end
                end
                prev_v  = rsp_valid && !rsp_ready;
                h_rdata = rsp_rdata;
                h_flags = {rsp_err, rsp_split};
                if (req_valid && req_ready) begin
                    hs_cyc = cyc + 1; wr_cnt = 0; beat_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        #1 rst = 1'b0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_payload", rsp_rdata | 32'({rsp_err, rsp_split}), 32'd0);
        check("rst_mem_port", mem_w_data | 32'(mem_addr) | 32'(mem_rw_mode) | 32'(mem_wr_en), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 12'h020, 32'h0000_0080, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 12'h020, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 12'h020, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 12'h022, 32'h0000_8001, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 12'h022, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 12'h022, 32'h0, 1'b1);
        for (int i = 1; i <= 4; i++) issue(1'b1, 2'b00, 1'b0, 12'(i), 32'(3 * i), 1'b1);
        issue(1'b0, 2'b10, 1'b0, 12'h001, 32'h0, 1'b1);
        issue(1'b1, 2'b01, 1'b0, 12'hFFF, 32'h0000_1234, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 12'hFFF, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 12'h000, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 12'hFFF, 32'h0, 1'b1);
        drain();

        rdy_mode = 2;
        issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b1);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(posedge clk);
            t++;
        end
        #2;
        check("bp_valid_seen", 32'(rsp_valid), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        check("bp_req_ready_low", 32'(req_ready), 32'd0);
        rdy_mode = 0;
        drain();
        issue(1'b0, 2'b11, 1'b0, 12'h030, 32'h0, 1'b1);
        issue(1'b1, 2'b11, 1'b0, 12'h031, 32'hFFFF_FFFF, 1'b1);
        drain();

        rdy_mode = 1;
        for (int n = 0; n < 150; n++) begin
            logic [1:0]    sz;
            logic [AW-1:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 1) == 1) ? 12'(12'hFFC + 12'($urandom_range(0, 7))) : 12'($urandom);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
        end
        drain();

        rdy_mode = 0;
        issue(1'b1, 2'b10, 1'b0, 12'h101, 32'hA1B2_C3D4, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_beat2_wr", 32'(mem_wr_en), 32'd1);
        check("rst_beat2_addr", 32'(mem_addr), 32'h103);
        #1 rst = 1'b0;
        #1;
        check("rst_wr_drop", 32'(mem_wr_en), 32'd0);
        check("rst_ready_async", 32'(req_ready), 32'd1);
        check("rst_valid_low", 32'(rsp_valid), 32'd0);
        ref_mem[12'h101] = 8'hD4;
        ref_mem[12'h102] = 8'hC3;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 4; i++) check("rst_mem_bytes", 32'(dmem[12'h100 + i]), 32'(ref_mem[12'h100 + i]));
        #2 rst = 1'b1;
        #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);
        for (int i = 1; i <= 4; i++) issue(1'b0, 2'b00, 1'b1, 12'(12'h100 + i), 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 12'h101, 32'h0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

CPU-side initiator for `data_memory`: accepts load/store requests from the execute stage over a valid/ready handshake and drives the memory's `wr_en`/`rw_mode`/`addr`/`w_data` port. It samples `r_data` and returns sign- or zero-extended load data, or a store completion, over a valid/ready response channel. Aligned accesses take one memory beat. Misaligned halfword/word accesses, which `data_memory` refuses, are split into ascending BYTE beats.

## Interface
- DMEM_DATA_WIDTH, 32, data width; only 32 is supported.
- DMEM_ADDR_WIDTH, 12, byte-address width; must match `data_memory`.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  BYTE=2'b00, HALFWORD=2'b01, WORD=2'b10; 2'b11 is illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  DMEM_ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal `req_size`.
- rsp_split  out  1  the access was executed as byte beats.
- mem_wr_en  out  1  to `data_memory.wr_en`.
- mem_rw_mode  out  2  to `data_memory.rw_mode`.
- mem_addr  out  DMEM_ADDR_WIDTH  to `data_memory.addr`.
- mem_w_data  out  32  to `data_memory.w_data`.
- mem_r_data  in  32  from `data_memory.r_data`; combinational read.

## Operation
- States: IDLE, BEAT, RESP.
- IDLE
  - `req_ready`=1.
  - Handshake is `req_valid && req_ready`.
  - On handshake, capture `we`, `size`, `unsigned`, `addr` and `wdata`, and clear the byte assembly register.
  - Illegal size: go directly to RESP with `rsp_err`=1.
  - Otherwise go to BEAT with beat counter=0.
- Split decision: split=1 when HALFWORD with `addr[0]`=1, or WORD with `addr[1:0]`≠0. BYTE is never split.
- Beat count: 1 if not split; 2 for split HALFWORD; 4 for split WORD.
- BEAT, unsplit
  - `mem_rw_mode`=size, `mem_addr`=addr, `mem_w_data`=wdata.
  - `mem_wr_en`=we.
  - Loads latch `mem_r_data` at end of cycle.
- BEAT k, split
  - `mem_rw_mode`=BYTE.
  - `mem_addr`=addr+k modulo 2^DMEM_ADDR_WIDTH, wrapping e.g. 0xFFF→0x000.
  - `mem_w_data`={24'b0, wdata[8k+7:8k]}.
  - `mem_wr_en`=we.
  - Loads store `mem_r_data[7:0]` into assembly byte k.
- After the last beat, go to RESP.
- Load extension, computed when entering RESP:
  - BYTE: bit 7 → bits 31:8.
  - HALFWORD: bit 15 → bits 31:16.
  - WORD: unchanged.
  - `req_unsigned`=1 forces zero fill.
- RESP
  - `rsp_valid`=1; `rsp_rdata`, `rsp_err` and `rsp_split` are stable.
  - Go to IDLE on `rsp_ready`.
  - A new request cannot be accepted in the same cycle, since `req_ready`=0 in RESP.
- Outside BEAT: `mem_wr_en`=0, `mem_rw_mode`=BYTE, `mem_addr`=0, `mem_w_data`=0.
- Request inputs are ignored outside the IDLE handshake. Changing them mid-access has no effect.

## Timing
- Reset, asynchronous when `rst`=0: state=IDLE and every output is 0, except `req_ready`=1 immediately.
  - `mem_wr_en` drops with no clock edge.
  - A split store interrupted by reset leaves the beats already issued written. No rollback.
- Latency, measured from the handshake edge to the edge on which `rsp_valid` rises:
  - unsplit: 2 cycles (1 BEAT cycle + entry into RESP);
  - split halfword: 3 cycles;
  - split word: 5 cycles;
  - illegal size: 1 cycle.
- Throughput: at most one request per (beats + 2) cycles with `rsp_ready` tied high.
- `rsp_valid` must not drop while `rsp_ready`=0, and its payload must not change.
- Exactly one `mem_wr_en` pulse per byte beat, or one for an unsplit store. Loads never assert it.
- Memory outputs must be register-driven, not a combinational path from `req_*`.

## Test plan
- **Aligned word store then load:** store 0xDEADBEEF at 0x010 → one beat with `mem_rw_mode`=WORD, `mem_wr_en`=1, and `rsp_valid` 2 cycles after the handshake. Signed word load from 0x010 → `rsp_rdata`=0xDEADBEEF, `rsp_split`=0.
- **Byte and halfword extension:** memory byte 0x80 at 0x020.
  - Signed BYTE load → 0xFFFFFF80; unsigned → 0x00000080.
  - Halfword 0x8001 at 0x022, signed → 0xFFFF8001.
- **Misaligned word load:** load from 0x001 with bytes 1..4 = 0x03,0x06,0x09,0x0C → four BYTE beats at 0x001..0x004. Require `rsp_rdata`=0x0C090603, `rsp_split`=1, latency 5 cycles.
- **Misaligned halfword store with wrap:** store 0x1234 at 0xFFF → two beats: byte 0x34 at 0xFFF, then 0x12 at 0x000, with two `mem_wr_en` pulses.
- **Backpressure and illegal size:**
  - Hold `rsp_ready`=0 for 3 cycles → `rsp_valid` and payload stable, `req_ready`=0.
  - `req_size`=2'b11 → no memory beat, `rsp_err`=1 after 1 cycle.
- **Reset mid-access:** assert `rst`=0 during beat 2 of a split word store → `mem_wr_en`=0 immediately, state IDLE, `req_ready`=1 after release. Only beats 0-1 are written.
